// File: rtl/gamma_bezier_pipe.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : gamma_bezier_pipe
//  Purpose  : Pipelined per-channel gamma correction through a cubic Bezier
//             transfer curve with fixed endpoints 0 and full scale and two
//             programmable control points per channel. Control points are
//             written to shadow registers and committed on the next
//             frame-start pixel, so a frame never mixes two curves.
//  Ports    : CLK, RESET_N (async, active-low)
//             BYPASS                       - pass samples through unchanged
//             DI_VALID, DI_FS, DI          - input qualifier, frame start, samples
//             DO_VALID, DO_FS, DO          - same, delayed by 4 cycles
//             CFG_WE, CFG_ALL, CFG_SEL     - shadow write strobe / target
//             CFG_P1, CFG_P2               - control points to write
//             CFG_PENDING                  - a shadow write awaits a frame start
//  Revision : 1.0 - initial release
// ============================================================================
module gamma_bezier_pipe #(
    parameter int DW   = 8,
    parameter int CH   = 3,
    parameter int CW   = 10,
    parameter int SELW = 3
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               BYPASS,
    input  logic               DI_VALID,
    input  logic               DI_FS,
    input  logic [CH*DW-1:0]   DI,
    output logic               DO_VALID,
    output logic               DO_FS,
    output logic [CH*DW-1:0]   DO,
    input  logic               CFG_WE,
    input  logic               CFG_ALL,
    input  logic [SELW-1:0]    CFG_SEL,
    input  logic [CW-1:0]      CFG_P1,
    input  logic [CW-1:0]      CFG_P2,
    output logic               CFG_PENDING
);

    // Wide enough that 3*u^2*t*P1 + 3*u*t^2*P2 + t^3*M can never wrap.
    localparam int IW = 3*DW + CW + 3;

    localparam int            c_M_INT  = (1 << CW) - 1;
    localparam logic [CW-1:0] c_M      = {CW{1'b1}};
    localparam logic [CW-1:0] c_P1_RST = CW'(c_M_INT / 3);
    localparam logic [CW-1:0] c_P2_RST = CW'((2 * c_M_INT) / 3);
    localparam logic [DW:0]   c_FULL   = {1'b1, {DW{1'b0}}};

    // ------------------------------------------------------------------------
    // Shadow-to-active commit control
    // ------------------------------------------------------------------------
    logic r_pending;
    logic w_commit;

    assign w_commit    = DI_VALID & DI_FS & r_pending;
    assign CFG_PENDING = r_pending;

    // A write in the commit cycle re-arms pending for the following frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending <= 1'b0;
        end else if (CFG_WE) begin
            r_pending <= 1'b1;
        end else if (w_commit) begin
            r_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Qualifier / bypass pipeline (shared by all channels)
    // ------------------------------------------------------------------------
    logic r1_v, r2_v, r3_v, r4_v;
    logic r1_fs, r2_fs, r3_fs, r4_fs;
    logic r1_byp, r2_byp, r3_byp;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r1_v   <= 1'b0;
            r2_v   <= 1'b0;
            r3_v   <= 1'b0;
            r4_v   <= 1'b0;
            r1_fs  <= 1'b0;
            r2_fs  <= 1'b0;
            r3_fs  <= 1'b0;
            r4_fs  <= 1'b0;
            r1_byp <= 1'b0;
            r2_byp <= 1'b0;
            r3_byp <= 1'b0;
        end else begin
            r1_v   <= DI_VALID;
            r2_v   <= r1_v;
            r3_v   <= r2_v;
            r4_v   <= r3_v;
            // Frame start only counts on a valid pixel.
            r1_fs  <= DI_VALID & DI_FS;
            r2_fs  <= r1_fs;
            r3_fs  <= r2_fs;
            r4_fs  <= r3_fs;
            r1_byp <= BYPASS;
            r2_byp <= r1_byp;
            r3_byp <= r2_byp;
        end
    end

    assign DO_VALID = r4_v;
    assign DO_FS    = r4_fs;

    // ------------------------------------------------------------------------
    // Per-channel coefficient registers and datapath
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [CW-1:0]   r_a_p1, r_a_p2, r_s_p1, r_s_p2;
        logic            w_hit;
        logic [DW-1:0]   w_x;

        // Stage registers
        logic [DW-1:0]   r1_t;
        logic [DW:0]     r1_u;
        logic [CW-1:0]   r1_p1, r1_p2;
        logic [2*DW-1:0] r2_t2;
        logic [2*DW:0]   r2_u2;
        logic [2*DW-1:0] r2_tu;
        logic [DW-1:0]   r2_t;
        logic [CW-1:0]   r2_p1, r2_p2;
        logic [IW-1:0]   r3_a, r3_b, r3_c;
        logic [DW-1:0]   r3_x;
        logic [DW-1:0]   r4_y;

        // Stage 4 combinational
        logic [IW-1:0]   w_sum, w_y;
        logic [CW-1:0]   w_yc;
        logic [DW-1:0]   w_out;

        // SELW is wide enough to address every channel, so the compare is exact.
        assign w_hit = CFG_WE & (CFG_ALL | (CFG_SEL == SELW'(k)));
        assign w_x   = DI[k*DW +: DW];

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_a_p1 <= c_P1_RST;
                r_a_p2 <= c_P2_RST;
                r_s_p1 <= c_P1_RST;
                r_s_p2 <= c_P2_RST;
            end else begin
                // Commit copies the pre-write shadow contents.
                if (w_commit) begin
                    r_a_p1 <= r_s_p1;
                    r_a_p2 <= r_s_p2;
                end
                if (w_hit) begin
                    r_s_p1 <= CFG_P1;
                    r_s_p2 <= CFG_P2;
                end
            end
        end

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r1_t  <= '0;
                r1_u  <= '0;
                r1_p1 <= '0;
                r1_p2 <= '0;
                r2_t2 <= '0;
                r2_u2 <= '0;
                r2_tu <= '0;
                r2_t  <= '0;
                r2_p1 <= '0;
                r2_p2 <= '0;
                r3_a  <= '0;
                r3_b  <= '0;
                r3_c  <= '0;
                r3_x  <= '0;
                r4_y  <= '0;
            end else begin
                // Stage 1: the committing pixel already sees the new curve.
                r1_t  <= w_x;
                r1_u  <= c_FULL - {1'b0, w_x};
                r1_p1 <= w_commit ? r_s_p1 : r_a_p1;
                r1_p2 <= w_commit ? r_s_p2 : r_a_p2;
                // Stage 2: squares and cross term.
                r2_t2 <= (2*DW)'(r1_t) * (2*DW)'(r1_t);
                r2_u2 <= (2*DW+1)'(r1_u) * (2*DW+1)'(r1_u);
                r2_tu <= (2*DW)'(r1_t) * (2*DW)'(r1_u);
                r2_t  <= r1_t;
                r2_p1 <= r1_p1;
                r2_p2 <= r1_p2;
                // Stage 3: Bernstein-weighted terms.
                r3_a  <= IW'(3) * IW'(r2_u2) * IW'(r2_t) * IW'(r2_p1);
                r3_b  <= IW'(3) * IW'(r2_tu) * IW'(r2_t) * IW'(r2_p2);
                r3_c  <= IW'(r2_t2) * IW'(r2_t) * IW'(c_M);
                r3_x  <= r2_t;
                // Stage 4: sum, normalise, clamp, select.
                r4_y  <= r3_byp ? r3_x : w_out;
            end
        end

        assign w_sum = r3_a + r3_b + r3_c;
        assign w_y   = w_sum >> (3*DW);
        assign w_yc  = (w_y > IW'(c_M)) ? c_M : w_y[CW-1:0];
        assign w_out = DW'(w_yc >> (CW - DW));

        assign DO[k*DW +: DW] = r4_y;
    end

endmodule
`default_nettype wire

// File: doc/gamma_bezier_pipe.md
# gamma_bezier_pipe

Parametrised, pipelined gamma-correction engine for the D8M video path, placed between the demosaic/colour stage and the HDMI output formatter. Each of CH channels maps a DW-bit sample through a cubic Bezier transfer curve. The curve has fixed endpoints 0 and full scale and two programmable control points per channel. Coefficients are written into shadow registers at any time and take effect on the first pixel of the next frame, so a frame is never split between two curves.

## Interface
Parameters:
- DW, 8, sample width per channel (2..12)
- CH, 3, channel count (1..8)
- CW, 10, control-point width; must satisfy CW >= DW
- SELW, 3, width of CFG_SEL; 2^SELW >= CH

Ports:
- CLK  in  1  pixel clock; all logic on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- BYPASS  in  1  1 = output equals input delayed by pipeline latency
- DI_VALID  in  1  input sample qualifier
- DI_FS  in  1  frame start; meaningful only when DI_VALID = 1
- DI  in  CH*DW  packed samples, channel k at [k*DW +: DW]
- DO_VALID  out  1  output qualifier
- DO_FS  out  1  frame start, aligned with DO
- DO  out  CH*DW  corrected samples, same packing as DI
- CFG_WE  in  1  shadow-register write strobe, one cycle
- CFG_ALL  in  1  1 = write all channels; CFG_SEL is ignored
- CFG_SEL  in  SELW  target channel; writes with CFG_SEL >= CH are discarded
- CFG_P1  in  CW  control point 1
- CFG_P2  in  CW  control point 2
- CFG_PENDING  out  1  a shadow write is waiting for a frame start

## Operation
- Per-channel registers: active pair A_P1/A_P2 and shadow pair S_P1/S_P2.
- Reset values of all four: A_P1 = S_P1 = (2^CW-1)/3 and A_P2 = S_P2 = 2*(2^CW-1)/3, integer division. For CW = 10 this is 341 and 682, a near-identity curve.
- CFG_WE loads the shadow pair of the selected channel, or of every channel when CFG_ALL = 1, and sets CFG_PENDING.
- Commit event: DI_VALID & DI_FS & CFG_PENDING.
  - Every channel copies shadow to active.
  - CFG_PENDING clears.
  - The committing pixel already uses the new curve.
- Same-cycle CFG_WE and commit: the commit copies the shadow contents from before the write. The new write lands in shadow and CFG_PENDING stays 1.
- Curve inputs, unsigned: t = x, u = 2^DW - x, M = 2^CW - 1.
- Curve value: y = (3·u²·t·P1 + 3·u·t²·P2 + t³·M) >> 3DW, truncated.
- Output: out = min(y, M) >> (CW - DW).
- Intermediate width: at least 3DW + CW + 3 bits. No wrap is permitted.
- Sampling at stage 1 with the pixel: active coefficients and BYPASS. A mid-frame BYPASS change therefore takes effect at an exact pixel boundary.
- In bypass, DO equals DI bit-exact at the same latency. Valid and FS pipelining are unchanged.
- Channels are independent and identical. Channel k uses only its own A_P1/A_P2.
- Invalid cycles advance the pipeline: no stall and no backpressure. Data on invalid output cycles is don't-care. DO_VALID and DO_FS are exact.

## Timing
- Fixed latency of 4 cycles: an input at edge n appears on DO at edge n+4. DO_VALID and DO_FS are the input qualifiers delayed by 4.
- Pipeline stages:
  1. Register x, u, coefficients, BYPASS and qualifiers.
  2. Form t², u², t·u.
  3. Form the three weighted products.
  4. Sum, shift, clamp, register the output.
- Throughput: one sample per channel per cycle, sustained.
- Reset, asserted asynchronously at any time including mid-frame:
  - DO_VALID = 0, DO_FS = 0, DO = 0, CFG_PENDING = 0.
  - Pipeline valids cleared; coefficients return to reset values.
  - After deassertion, the first valid output appears 4 cycles after the first DI_VALID.
- CFG_PENDING rises the cycle after CFG_WE. It falls the cycle after the commit pixel is accepted.
- Back-to-back CFG_WE: last write wins per channel. CFG_PENDING stays 1.
- DI_FS without DI_VALID is ignored and commits nothing.

## Test plan
- Reset coefficients, CW=10, DW=8, ramp input x = 0, 128, 255 on all channels -> DO = 0, 127, 254 respectively, at exactly 4 cycles; DO_VALID matches the DI_VALID pattern, including gaps.
- CFG_ALL write P1 = P2 = 0, then FS pixel x = 128 -> that pixel and later pixels give 31. Before the FS, outputs stay 127 and CFG_PENDING = 1. It clears after the FS.
- CFG_SEL = 1, P1 = P2 = 1023, committed by FS -> channel 1 at x = 128 gives 223 (y = 895). Channels 0 and 2 stay 127. CFG_SEL = 5 with CH = 3 -> no change, CFG_PENDING still sets.
- CFG_WE in the same cycle as the FS pixel -> that frame uses the old coefficients and CFG_PENDING remains 1. The next FS applies the new ones.
- BYPASS toggled mid-stream with random DI -> DO equals DI delayed by 4 exactly for pixels accepted while BYPASS = 1, with the curve applied elsewhere. The switch occurs on the exact pixel.
- RESET_N pulsed low for one cycle mid-frame after a pending write -> outputs 0 immediately. CFG_PENDING = 0. The next frame uses the reset curve: x = 128 gives 127.
